fetch_sequencer: RTL and testbench

Fetch-stage controller for the A/B accumulator pipeline. It owns the program counter and sequences instruction fetch from the instruction ROM. It handles branch redirects (flushing the IF/ID latch), load-use stalls (freezing the PC and the IF/ID latch for a programmable number of cycles) and halt/resume. A saturating bubble counter is provided for performance debug.

---
 rtl/fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller for the A/B accumulator pipeline.
// Handles branch redirects, load-use stalls, halt/resume and a saturating bubble counter.
`default_nettype none

module fetch_sequencer #(
  parameter int PC_WIDTH              = 10,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int STALL_CYCLES          = 1
) (
  input  logic                iClock,
  input  logic                iReset_n,
  input  logic                iBranchTaken,
  input  logic [PC_WIDTH-1:0] iBranchTarget,
  input  logic                iLoadUseHazard,
  input  logic                iHalt,
  input  logic                iResume,
  output logic [PC_WIDTH-1:0] oPC,
  output logic                oFetchValid,
  output logic                oStall,
  output logic                oFlush,
  output logic [2:0]          oState,
  output logic [15:0]         oBubbleCount
);

  localparam logic [2:0] c_START    = 3'd0;
  localparam logic [2:0] c_RUN      = 3'd1;
  localparam logic [2:0] c_REDIRECT = 3'd2;
  localparam logic [2:0] c_STALL    = 3'd3;
  localparam logic [2:0] c_HALT     = 3'd4;

  localparam logic [PC_WIDTH-1:0] c_RESET_PC   = RESET_VECTOR[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] c_PC_ONE     = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]          c_STALL_LOAD = 3'(STALL_CYCLES - 1);

  logic [2:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_valid;
  logic                r_stall;
  logic                r_flush;
  logic [2:0]          r_cnt;
  logic [15:0]         r_bubble;

  logic [2:0]          w_state_nxt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic                w_valid_nxt;
  logic                w_stall_nxt;
  logic                w_flush_nxt;
  logic [2:0]          w_cnt_nxt;
  logic [15:0]         w_bubble_nxt;

  assign w_pc_inc = r_pc + c_PC_ONE;

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= c_START;
      r_pc     <= c_RESET_PC;
      r_valid  <= 1'b0;
      r_stall  <= 1'b0;
      r_flush  <= 1'b0;
      r_cnt    <= 3'd0;
      r_bubble <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_valid  <= w_valid_nxt;
      r_stall  <= w_stall_nxt;
      r_flush  <= w_flush_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bubble <= w_bubble_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_START:    w_state_nxt = c_RUN;
      c_RUN: begin
        if (iBranchTaken)        w_state_nxt = c_REDIRECT;
        else if (iHalt)          w_state_nxt = c_HALT;
        else if (iLoadUseHazard) w_state_nxt = c_STALL;
      end
      c_REDIRECT: w_state_nxt = c_RUN;
      c_STALL: begin
        if (iBranchTaken)        w_state_nxt = c_REDIRECT;
        else if (r_cnt == 3'd0)  w_state_nxt = c_RUN;
      end
      c_HALT: begin
        if (iResume)             w_state_nxt = c_RUN;
      end
      default:    w_state_nxt = c_START;
    endcase
  end

  // Next values of the registered outputs; every output is a flop.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_stall_nxt = r_stall;
    w_flush_nxt = r_flush;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_START: w_valid_nxt = 1'b1;
      c_RUN: begin
        if (iBranchTaken) begin
          w_pc_nxt    = iBranchTarget;
          w_flush_nxt = 1'b1;
          w_valid_nxt = 1'b0;
        end else if (iHalt) begin
          w_valid_nxt = 1'b0;
        end else if (iLoadUseHazard) begin
          w_stall_nxt = 1'b1;
          w_cnt_nxt   = c_STALL_LOAD;
        end else begin
          w_pc_nxt    = w_pc_inc;
        end
      end
      c_REDIRECT: begin
        w_flush_nxt = 1'b0;
        w_valid_nxt = 1'b1;
        w_pc_nxt    = w_pc_inc;
      end
      c_STALL: begin
        if (iBranchTaken) begin
          w_stall_nxt = 1'b0;
          w_pc_nxt    = iBranchTarget;
          w_flush_nxt = 1'b1;
          w_valid_nxt = 1'b0;
        end else if (r_cnt == 3'd0) begin
          w_stall_nxt = 1'b0;
          w_pc_nxt    = w_pc_inc;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      c_HALT: begin
        w_valid_nxt = iResume;
      end
      default: ;
    endcase
  end

  assign w_bubble_nxt = (!r_valid && (r_state != c_START) && (r_bubble != 16'hFFFF))
                        ? r_bubble + 16'd1 : r_bubble;

  assign oPC          = r_pc;
  assign oFetchValid  = r_valid;
  assign oStall       = r_stall;
  assign oFlush       = r_flush;
  assign oState       = r_state;
  assign oBubbleCount = r_bubble;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer (PC_WIDTH=10, STALL_CYCLES=3).
`default_nettype none

module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       br;
  logic [9:0] tgt;
  logic       haz;
  logic       hlt;
  logic       res;
  logic [9:0] pc;
  logic       fv;
  logic       st;
  logic       fl;
  logic [2:0] state;
  logic [15:0] bub;

  typedef struct {
    logic [9:0]  pc;
    logic        fv;
    logic        st;
    logic        fl;
    logic [2:0]  state;
    logic [15:0] bub;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_sequencer #(
    .PC_WIDTH(10),
    .RESET_VECTOR(0),
    .STALL_CYCLES(3)
  ) dut (
    .iClock(clk),
    .iReset_n(rst_n),
    .iBranchTaken(br),
    .iBranchTarget(tgt),
    .iLoadUseHazard(haz),
    .iHalt(hlt),
    .iResume(res),
    .oPC(pc),
    .oFetchValid(fv),
    .oStall(st),
    .oFlush(fl),
    .oState(state),
    .oBubbleCount(bub)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [9:0] e_pc, input logic e_fv, input logic e_st,
                      input logic e_fl, input logic [2:0] e_state, input logic [15:0] e_bub);
    exp_t e;
    e.pc = e_pc; e.fv = e_fv; e.st = e_st; e.fl = e_fl; e.state = e_state; e.bub = e_bub;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},    {6'd0, pc},     {6'd0, e.pc});
      chk({tag, ".valid"}, {15'd0, fv},    {15'd0, e.fv});
      chk({tag, ".stall"}, {15'd0, st},    {15'd0, e.st});
      chk({tag, ".flush"}, {15'd0, fl},    {15'd0, e.fl});
      chk({tag, ".state"}, {13'd0, state}, {13'd0, e.state});
      chk({tag, ".bubble"}, bub,           e.bub);
    end
  endtask

  // One clock: drive inputs, record expectation, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input logic i_br, input logic [9:0] i_tgt,
                     input logic i_haz, input logic i_hlt, input logic i_res,
                     input logic [9:0] e_pc, input logic e_fv, input logic e_st,
                     input logic e_fl, input logic [2:0] e_state, input logic [15:0] e_bub);
    br = i_br; tgt = i_tgt; haz = i_haz; hlt = i_hlt; res = i_res;
    push(e_pc, e_fv, e_st, e_fl, e_state, e_bub);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n = 1'b0; br = 1'b0; tgt = '0; haz = 1'b0; hlt = 1'b0; res = 1'b0;
    #2;
    push(10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    compare("reset");
    #10;
    rst_n = 1'b1;

    // Free run from the reset vector
    cyc("start",  0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 0, 3'd1, 16'd0);
    cyc("run1",   0, 10'h000, 0, 0, 0, 10'h001, 1, 0, 0, 3'd1, 16'd0);
    cyc("run2",   0, 10'h000, 0, 0, 0, 10'h002, 1, 0, 0, 3'd1, 16'd0);
    cyc("run3",   0, 10'h000, 0, 0, 0, 10'h003, 1, 0, 0, 3'd1, 16'd0);
    cyc("run4",   0, 10'h000, 0, 0, 0, 10'h004, 1, 0, 0, 3'd1, 16'd0);
    cyc("run5",   0, 10'h000, 0, 0, 0, 10'h005, 1, 0, 0, 3'd1, 16'd0);

    // Branch at PC 5 to 0x3F0: one bubble
    cyc("branch", 1, 10'h3F0, 0, 0, 0, 10'h3F0, 0, 0, 1, 3'd2, 16'd0);
    cyc("redir",  0, 10'h000, 0, 0, 0, 10'h3F1, 1, 0, 0, 3'd1, 16'd1);
    for (int p = 'h3F2; p <= 'h3FF; p++)
      cyc("seq_hi", 0, 10'h000, 0, 0, 0, 10'(p), 1, 0, 0, 3'd1, 16'd1);
    for (int p = 0; p <= 8; p++)
      cyc("wrap",   0, 10'h000, 0, 0, 0, 10'(p), 1, 0, 0, 3'd1, 16'd1);

    // Load-use at PC 8: three stall cycles then advance
    cyc("haz",    0, 10'h000, 1, 0, 0, 10'h008, 1, 1, 0, 3'd3, 16'd1);
    cyc("stall2", 0, 10'h000, 0, 0, 0, 10'h008, 1, 1, 0, 3'd3, 16'd1);
    cyc("stall3", 0, 10'h000, 0, 0, 0, 10'h008, 1, 1, 0, 3'd3, 16'd1);
    cyc("unstall",0, 10'h000, 0, 0, 0, 10'h009, 1, 0, 0, 3'd1, 16'd1);

    // Branch in the second stall cycle; a halt here is ignored
    cyc("haz2",   0, 10'h000, 1, 0, 0, 10'h009, 1, 1, 0, 3'd3, 16'd1);
    cyc("st2_2",  0, 10'h000, 0, 1, 0, 10'h009, 1, 1, 0, 3'd3, 16'd1);
    cyc("st_br",  1, 10'h020, 0, 0, 0, 10'h020, 0, 0, 1, 3'd2, 16'd1);
    cyc("st_red", 0, 10'h000, 0, 0, 0, 10'h021, 1, 0, 0, 3'd1, 16'd2);

    // All three events together: branch wins; halt held through REDIRECT is ignored there
    cyc("prio",   1, 10'h00A, 1, 1, 0, 10'h00A, 0, 0, 1, 3'd2, 16'd2);
    cyc("prio_r", 0, 10'h000, 1, 1, 0, 10'h00B, 1, 0, 0, 3'd1, 16'd3);
    cyc("run_c",  0, 10'h000, 0, 0, 0, 10'h00C, 1, 0, 0, 3'd1, 16'd3);

    // Halt at PC 12 for four bubble cycles, branch ignored, resume re-fetches
    cyc("halt",   0, 10'h000, 0, 1, 0, 10'h00C, 0, 0, 0, 3'd4, 16'd3);
    cyc("hold1",  0, 10'h000, 0, 0, 0, 10'h00C, 0, 0, 0, 3'd4, 16'd4);
    cyc("hold_br",1, 10'h003, 0, 0, 0, 10'h00C, 0, 0, 0, 3'd4, 16'd5);
    cyc("hold3",  0, 10'h000, 0, 0, 0, 10'h00C, 0, 0, 0, 3'd4, 16'd6);
    cyc("resume", 0, 10'h000, 0, 0, 1, 10'h00C, 1, 0, 0, 3'd1, 16'd7);
    cyc("post_r", 0, 10'h000, 0, 0, 0, 10'h00D, 1, 0, 0, 3'd1, 16'd7);

    // Asynchronous reset in the middle of a stall
    cyc("haz3",   0, 10'h000, 1, 0, 0, 10'h00D, 1, 1, 0, 3'd3, 16'd7);
    haz = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    push(10'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    compare("async_rst");
    #2;
    rst_n = 1'b1;
    cyc("restart",0, 10'h000, 0, 0, 0, 10'h000, 1, 0, 0, 3'd1, 16'd0);
    cyc("rerun",  0, 10'h000, 0, 0, 0, 10'h001, 1, 0, 0, 3'd1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
